// File: rtl/mux_sel_scanner.sv
// Walks the 4:1 mux select through channels 0..3, samples each after a settle
// delay, and publishes all four samples at once as a snapshot.
module mux_sel_scanner #(
  parameter int DWIDTH = 1,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cont,
  input  logic                  abort,
  input  logic [DWIDTH-1:0]     mux_out,
  output logic [1:0]            sel,
  output logic                  busy,
  output logic                  done,
  output logic [4*DWIDTH-1:0]   snapshot
);

  // state  | meaning
  // IDLE   | waiting for start, sel parked on channel 0
  // SETTLE | sel held while the mux output settles
  // SAMPLE | capture current channel, advance or publish
  // DONE   | one-cycle done pulse, optional continuous restart
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [4*DWIDTH-1:0] shadow_q, shadow_d;
  logic [4*DWIDTH-1:0] snap_q, snap_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= 2'd0;
      cnt_q    <= 4'd0;
      shadow_q <= '0;
      snap_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      snap_q   <= snap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    snap_d   = snap_q;

    if (abort && state_q != S_IDLE) begin
      // abort beats sampling, so a partial shadow is never published
      state_d  = S_IDLE;
      sel_d    = 2'd0;
      shadow_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          sel_d = 2'd0;
          if (start) begin
            cnt_d   = RELOAD;
            state_d = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          else               state_d = S_SAMPLE;
        end
        S_SAMPLE: begin
          shadow_d[sel_q*DWIDTH +: DWIDTH] = mux_out;
          if (sel_q != 2'd3) begin
            sel_d   = sel_q + 2'd1;
            cnt_d   = RELOAD;
            state_d = S_SETTLE;
          end else begin
            snap_d  = shadow_d;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          sel_d = 2'd0;
          if (cont) begin
            cnt_d   = RELOAD;
            state_d = S_SETTLE;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign sel      = sel_q;
  assign busy     = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done     = (state_q == S_DONE);
  assign snapshot = snap_q;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Bench for mux_sel_scanner: combinational mux model, snapshot scoreboard
// popped on every done pulse, plus per-scenario cycle checks.
module tb_mux_sel_scanner;

  logic       clk = 1'b0;
  logic       rst, start, cont, abort;
  logic [0:0] mux_out;
  logic [1:0] sel;
  logic       busy, done;
  logic [3:0] snapshot;
  logic [3:0] in_v;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  assign mux_out = in_v[sel];

  mux_sel_scanner #(.DWIDTH(1), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
    .mux_out(mux_out), .sel(sel), .busy(busy), .done(done), .snapshot(snapshot)
  );

  always @(negedge clk) begin
    if (done === 1'b1) begin
      logic [3:0] e;
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done at %0t snapshot=%b", $time, snapshot);
      end else begin
        e = exp_q.pop_front();
        if (snapshot !== e) begin
          errors++;
          $display("FAIL snapshot_at_done got=%b want=%b", snapshot, e);
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0; in_v = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({sel, busy, done, snapshot} !== 8'b0) begin
        errors++;
        $display("FAIL reset_idle sel=%0d busy=%b done=%b snap=%b want all 0", sel, busy, done, snapshot);
      end
    end
  endtask

  task automatic test_single();
    logic [1:0] es;
    in_v = 4'b1101;
    exp_q.push_back(4'b1101);
    pulse_start();
    for (int c = 1; c <= 14; c++) begin
      checks++;
      if (busy !== (c <= 12)) begin
        errors++;
        $display("FAIL single_busy c=%0d got=%b want=%b", c, busy, (c <= 12));
      end
      checks++;
      if (done !== (c == 13)) begin
        errors++;
        $display("FAIL single_done c=%0d got=%b want=%b", c, done, (c == 13));
      end
      if (c <= 12 || c == 14) begin
        es = (c == 14) ? 2'd0 : 2'((c - 1) / 3);
        checks++;
        if (sel !== es) begin
          errors++;
          $display("FAIL single_sel c=%0d got=%0d want=%0d", c, sel, es);
        end
      end
      if (c == 12) begin
        checks++;
        if (snapshot !== 4'b0000) begin
          errors++;
          $display("FAIL single_atomic c=12 got=%b want=0000", snapshot);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_continuous();
    in_v = 4'b1101;
    cont = 1'b1;
    exp_q.push_back(4'b0101);
    exp_q.push_back(4'b0110);
    pulse_start();
    for (int c = 1; c <= 28; c++) begin
      if (c == 7) in_v = 4'b0110;
      if (c == 14) begin
        cont = 1'b0;
        checks++;
        if (sel !== 2'd0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL cont_restart sel=%0d busy=%b want sel=0 busy=1", sel, busy);
        end
      end
      if (c == 27) begin
        checks++;
        if (sel !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL cont_stop sel=%0d busy=%b done=%b want 0 0 0", sel, busy, done);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL cont_pending got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    in_v = 4'b1111;
    pulse_start();
    for (int c = 1; c < 7; c++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (sel !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle sel=%0d busy=%b done=%b want 0 0 0", sel, busy, done);
    end
    repeat (16) @(negedge clk);
    checks++;
    if (done_cnt != d0 || snapshot !== 4'b0110) begin
      errors++;
      $display("FAIL abort_keep dones=%0d want=%0d snap=%b want=0110", done_cnt - d0, 0, snapshot);
    end
  endtask

  task automatic test_ignored_start();
    int d0, nbusy;
    d0 = done_cnt;
    nbusy = 0;
    in_v = 4'b1101;
    exp_q.push_back(4'b1101);
    pulse_start();
    for (int c = 1; c <= 30; c++) begin
      if (busy === 1'b1) nbusy++;
      start = (c == 5) || (c == 13);
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (nbusy != 12) begin
      errors++;
      $display("FAIL ign_busy_len got=%0d want=12", nbusy);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL ign_done_count got=%0d want=1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    in_v = 4'b0011;
    pulse_start();
    for (int c = 1; c < 12; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({sel, busy, done, snapshot} !== 8'b0) begin
      errors++;
      $display("FAIL rst_mid sel=%0d busy=%b done=%b snap=%b want all 0", sel, busy, done, snapshot);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL rst_mid_done got=%0d want=0", done_cnt - d0);
    end
    in_v = 4'b1010;
    exp_q.push_back(4'b1010);
    pulse_start();
    repeat (15) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_rescan dones=%0d want=1 pending=%0d want=0", done_cnt - d0, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    // start and abort together in IDLE: start wins
    in_v = 4'b0111;
    exp_q.push_back(4'b0111);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_abort_idle busy got=%b want=1", busy);
    end
    repeat (14) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || snapshot !== 4'b0111) begin
      errors++;
      $display("FAIL start_abort_result pending=%0d snap=%b want=0111", exp_q.size(), snapshot);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_continuous();
    test_abort();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
